// File: rtl/bus_arbiter_2_pkg.sv
// rtl/bus_arbiter_2_pkg.sv - shared state encodings and defaults for the two-way arbiter
package bus_arbiter_2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } arb_state_t;

   localparam int DEFAULT_MAX_HOLD = 8;
   localparam int HOLD_W           = 8;

endpackage

// File: rtl/mux_2_1.sv
// rtl/mux_2_1.sv - generic 2:1 word multiplexer, sel=0 picks d1
module mux_2_1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? d2 : d1;

endmodule

// File: rtl/bus_arbiter_2.sv
// rtl/bus_arbiter_2.sv - two-requester round-robin arbiter with bounded hold driving a shared 2:1 port
module bus_arbiter_2
   import bus_arbiter_2_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_valid
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_t        state;
   arb_state_t        nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              last;
   logic              contend;

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (req0 && req1)  nxt = last ? G0 : G1;
            else if (req0)     nxt = G0;
            else if (req1)     nxt = G1;
         end
         G0: begin
            if (!req0)                          nxt = req1 ? G1 : IDLE;
            else if (req1 && hold_cnt == HOLD_LAST) nxt = G1;
         end
         G1: begin
            if (!req1)                          nxt = req0 ? G0 : IDLE;
            else if (req0 && hold_cnt == HOLD_LAST) nxt = G0;
         end
         default: nxt = IDLE;
      endcase
   end

   // hold_cnt only advances while the non-owner is actually waiting
   assign contend = ((state == G0) && req1) || ((state == G1) && req0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         sel      <= 1'b0;
         hold_cnt <= '0;
         last     <= 1'b1;
      end else begin
         state <= nxt;
         gnt0  <= (nxt == G0);
         gnt1  <= (nxt == G1);
         sel   <= (nxt == G1);
         if ((nxt != state) && (nxt != IDLE)) begin
            hold_cnt <= '0;
            last     <= (nxt == G1);
         end else if (contend && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   assign bus_valid = (gnt0 & req0) | (gnt1 & req1);

   mux_2_1 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .d1  (d0),
      .d2  (d1),
      .sel (sel),
      .y   (bus_out)
   );

endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb/tb_bus_arbiter_2.sv - directed bench with a cycle-level reference model for bus_arbiter_2
module tb_bus_arbiter_2;

   typedef struct packed {
      int owner;
      int cont;
      int last;
   } mstate_t;

   logic        clk = 1'b0;
   logic        rst_a, req0_a, req1_a;
   logic [31:0] d0_a, d1_a, bus_out_a;
   logic        gnt0_a, gnt1_a, sel_a, bus_valid_a;
   logic        rst_b, req0_b, req1_b;
   logic [31:0] d0_b, d1_b, bus_out_b;
   logic        gnt0_b, gnt1_b, sel_b, bus_valid_b;

   int          errors  = 0;
   int          checks  = 0;
   logic        started = 1'b0;
   mstate_t     ma = '{owner: 0, cont: 0, last: 1};
   mstate_t     mb = '{owner: 0, cont: 0, last: 1};
   logic        exp_b [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   bus_arbiter_2 #(.WIDTH(32), .MAX_HOLD(8)) dut_a (
      .clk(clk), .rst(rst_a), .req0(req0_a), .req1(req1_a), .d0(d0_a), .d1(d1_a),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .bus_out(bus_out_a), .bus_valid(bus_valid_a)
   );

   bus_arbiter_2 #(.WIDTH(32), .MAX_HOLD(1)) dut_b (
      .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b), .d0(d0_b), .d1(d1_b),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .bus_out(bus_out_b), .bus_valid(bus_valid_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // owner: 0 = nobody, 1 = requester 0, 2 = requester 1; cont counts contended cycles of the current grant
   function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic r0,
                                          input logic r1, input int max_hold);
      mstate_t n = s;
      int      win;
      logic    mine, theirs;
      if (rst) begin
         n.owner = 0; n.cont = 0; n.last = 1;
         return n;
      end
      if (s.owner == 0) begin
         if (r0 && r1)  win = (s.last == 1) ? 1 : 2;
         else if (r0)   win = 1;
         else if (r1)   win = 2;
         else           win = 0;
      end else begin
         mine   = (s.owner == 1) ? r0 : r1;
         theirs = (s.owner == 1) ? r1 : r0;
         if (!mine)                          win = theirs ? 3 - s.owner : 0;
         else if (theirs && s.cont + 1 >= max_hold) win = 3 - s.owner;
         else begin
            win = s.owner;
            if (theirs) n.cont = s.cont + 1;
         end
      end
      if (win != s.owner) begin
         n.cont = 0;
         if (win != 0) n.last = win - 1;
      end
      n.owner = win;
      return n;
   endfunction

   always @(posedge clk) begin
      ma <= model_next(ma, rst_a, req0_a, req1_a, 8);
      mb <= model_next(mb, rst_b, req0_b, req1_b, 1);
   end

   always @(negedge clk) begin
      if (started) begin
         check("a_gnt0",  gnt0_a, ma.owner == 1);
         check("a_gnt1",  gnt1_a, ma.owner == 2);
         check("a_sel",   sel_a,  ma.owner == 2);
         check("a_valid", bus_valid_a, (ma.owner == 1 && req0_a) || (ma.owner == 2 && req1_a));
         check("a_bus",   bus_out_a, (ma.owner == 2) ? d1_a : d0_a);
         check("a_mutex", gnt0_a & gnt1_a, 1'b0);
         check("b_gnt0",  gnt0_b, mb.owner == 1);
         check("b_gnt1",  gnt1_b, mb.owner == 2);
         check("b_valid", bus_valid_b, (mb.owner == 1 && req0_b) || (mb.owner == 2 && req1_b));
         check("b_bus",   bus_out_b, (mb.owner == 2) ? d1_b : d0_b);
         check("b_mutex", gnt0_b & gnt1_b, 1'b0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0; d0_a = '0; d1_a = '0;
      rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; d0_b = '0; d1_b = '0;

      // reset then idle
      step();
      started = 1'b1;
      step();
      #3;
      check("rst_gnt0",  gnt0_a, 1'b0);
      check("rst_gnt1",  gnt1_a, 1'b0);
      check("rst_sel",   sel_a,  1'b0);
      check("rst_valid", bus_valid_a, 1'b0);
      req0_a = 1'b1;
      step();
      #3;
      check("rst_blocks_gnt", gnt0_a, 1'b0);

      // single requester
      rst_a = 1'b0; d0_a = 32'hDEADBEEF; d1_a = 32'h0BADF00D;
      step();
      #3;
      check("single_gnt0",  gnt0_a, 1'b1);
      check("single_bus",   bus_out_a, 32'hDEADBEEF);
      check("single_valid", bus_valid_a, 1'b1);
      repeat (3) step();
      req0_a = 1'b0;
      #3;
      check("drop_valid", bus_valid_a, 1'b0);
      check("drop_gnt_held", gnt0_a, 1'b1);
      step();
      #3;
      check("drop_gnt0", gnt0_a, 1'b0);

      // simultaneous first request, MAX_HOLD=8
      rst_a = 1'b1;
      step();
      rst_a = 1'b0; req0_a = 1'b1; req1_a = 1'b1; d0_a = 32'h1; d1_a = 32'h2;
      step();
      #3;
      check("tie_g0_first", gnt0_a, 1'b1);
      check("tie_bus", bus_out_a, 32'h1);
      repeat (7) step();
      #3;
      check("hold8_g0", gnt0_a, 1'b1);
      step();
      #3;
      check("hold8_g1",  gnt1_a, 1'b1);
      check("hold8_sel", sel_a, 1'b1);
      check("hold8_bus", bus_out_a, 32'h2);

      // voluntary release from G1 after 3 cycles
      step();
      step();
      req1_a = 1'b0;
      #3;
      check("release_valid", bus_valid_a, 1'b0);
      step();
      #3;
      check("release_no_gap", gnt0_a, 1'b1);
      req1_a = 1'b1;
      repeat (7) step();
      #3;
      check("restart_g0", gnt0_a, 1'b1);
      step();
      #3;
      check("restart_g1", gnt1_a, 1'b1);

      // reset mid-grant with hold_cnt at 5
      repeat (5) step();
      #3;
      check("mid_g1", gnt1_a, 1'b1);
      rst_a = 1'b1;
      step();
      #3;
      check("mid_rst_gnt1", gnt1_a, 1'b0);
      check("mid_rst_gnt0", gnt0_a, 1'b0);
      rst_a = 1'b0;
      step();
      #3;
      check("post_rst_g0", gnt0_a, 1'b1);
      req0_a = 1'b0; req1_a = 1'b0;

      // MAX_HOLD=1 continuous contention
      rst_b = 1'b0; req0_b = 1'b1; req1_b = 1'b1; d0_b = 32'hA0A0A0A0; d1_b = 32'h5B5B5B5B;
      for (int i = 0; i < 6; i++) begin
         step();
         #3;
         check("alt_gnt1", gnt1_b, exp_b[i]);
         check("alt_gnt0", gnt0_b, !exp_b[i]);
      end
      req0_b = 1'b0; req1_b = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
